// File: rtl/addr_mode_sequencer.sv
// -----------------------------------------------------------------------------
// addr_mode_sequencer
//
// Front end of the addressing flag generators. It accepts a fetched opcode,
// latches it, decodes its 6502 addressing mode and then steps the addressing
// state counter (A0..A5), one state per unstalled cycle. When addressing is
// complete it raises addr_done and holds it until the execute stage
// acknowledges it.
//
// Optional feature macro: PAGE_CROSS_PENALTY_EN
//   When defined, ABS_X, ABS_Y and IND_Y issue one extra state if page_cross
//   is high in their final state. Stores (aaa=100, cc=01) always take the
//   extra state. When undefined, page_cross is ignored.
//
// Ports:
//   clk           system clock
//   nrst          synchronous active-low reset
//   opcode_valid  fetch presents a new opcode this cycle
//   opCode        fetched opcode
//   hold          stall (RDY low); freezes the sequencer outside DONE
//   exec_ack      execute stage has consumed the addressing results
//   page_cross    carry out of the low-address add (optional feature only)
//   opcode_ready  sequencer is idle and can take an opcode
//   opcode_q      latched opcode
//   mode          decoded addressing mode of the latched opcode
//   state         current addressing state (valid while addr_active)
//   addr_active   addressing states are being issued
//   addr_done     addressing finished; held until exec_ack
//   illegal       latched opcode has cc=11
// -----------------------------------------------------------------------------
module addr_mode_sequencer #(
   parameter int STATE_W = 4,
   parameter int MODE_W  = 4
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               opcode_valid,
   input  logic [7:0]         opCode,
   input  logic               hold,
   input  logic               exec_ack,
   input  logic               page_cross,
   output logic               opcode_ready,
   output logic [7:0]         opcode_q,
   output logic [MODE_W-1:0]  mode,
   output logic [STATE_W-1:0] state,
   output logic               addr_active,
   output logic               addr_done,
   output logic               illegal
);

   localparam logic [MODE_W-1:0] M_IMP   = MODE_W'(0);
   localparam logic [MODE_W-1:0] M_IMM   = MODE_W'(1);
   localparam logic [MODE_W-1:0] M_ZPG   = MODE_W'(2);
   localparam logic [MODE_W-1:0] M_ZPG_X = MODE_W'(3);
   localparam logic [MODE_W-1:0] M_ZPG_Y = MODE_W'(4);
   localparam logic [MODE_W-1:0] M_ABS   = MODE_W'(5);
   localparam logic [MODE_W-1:0] M_ABS_X = MODE_W'(6);
   localparam logic [MODE_W-1:0] M_ABS_Y = MODE_W'(7);
   localparam logic [MODE_W-1:0] M_IND_X = MODE_W'(8);
   localparam logic [MODE_W-1:0] M_IND_Y = MODE_W'(9);
   localparam logic [MODE_W-1:0] M_REL   = MODE_W'(10);
   localparam logic [MODE_W-1:0] M_IND   = MODE_W'(11);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DONE = 2'd2
   } fsm_t;

   fsm_t               fsm, fsm_nxt;
   logic [7:0]         opcode_nxt;
   logic [MODE_W-1:0]  mode_nxt;
   logic [STATE_W-1:0] state_nxt;
   logic               illegal_nxt;

   logic [2:0]         aaa, bbb;
   logic [1:0]         cc;
   logic [MODE_W-1:0]  dec_mode;
   logic [2:0]         cur_count;
   logic               last_state;
   logic               exit_addr;

   // Number of addressing states each mode needs before execute can start.
   function automatic logic [2:0] mode_count(input logic [MODE_W-1:0] m);
      logic [2:0] c;
      c = 3'd0;
      case (m)
         M_ZPG:                     c = 3'd1;
         M_ZPG_X, M_ZPG_Y, M_ABS:   c = 3'd2;
         M_ABS_X, M_ABS_Y, M_IND_X: c = 3'd3;
         M_IND_Y, M_IND:            c = 3'd4;
         default:                   c = 3'd0;
      endcase
      return c;
   endfunction

   assign aaa = opCode[7:5];
   assign bbb = opCode[4:2];
   assign cc  = opCode[1:0];

   // Addressing-mode decode of the incoming opcode. The cc=10 group swaps
   // X indexing for Y on the LDX/STX rows, and the cc=00 group has the
   // JSR (0x20) and JMP indirect (0x6C) special cases.
   always_comb begin
      dec_mode = M_IMP;
      case (cc)
         2'b01: begin
            case (bbb)
               3'b000: dec_mode = M_IND_X;
               3'b001: dec_mode = M_ZPG;
               3'b010: dec_mode = M_IMM;
               3'b011: dec_mode = M_ABS;
               3'b100: dec_mode = M_IND_Y;
               3'b101: dec_mode = M_ZPG_X;
               3'b110: dec_mode = M_ABS_Y;
               3'b111: dec_mode = M_ABS_X;
               default: dec_mode = M_IMP;
            endcase
         end
         2'b10: begin
            case (bbb)
               3'b000: dec_mode = M_IMM;
               3'b001: dec_mode = M_ZPG;
               3'b011: dec_mode = M_ABS;
               3'b101: dec_mode = (aaa == 3'b100 || aaa == 3'b101) ? M_ZPG_Y : M_ZPG_X;
               3'b111: dec_mode = (aaa == 3'b101) ? M_ABS_Y : M_ABS_X;
               default: dec_mode = M_IMP;
            endcase
         end
         2'b00: begin
            case (bbb)
               3'b000: begin
                  if (opCode == 8'h20)
                     dec_mode = M_ABS;
                  else if (aaa >= 3'b101)
                     dec_mode = M_IMM;
                  else
                     dec_mode = M_IMP;
               end
               3'b001: dec_mode = M_ZPG;
               3'b011: dec_mode = (opCode == 8'h6C) ? M_IND : M_ABS;
               3'b100: dec_mode = M_REL;
               3'b101: dec_mode = M_ZPG_X;
               3'b111: dec_mode = M_ABS_X;
               default: dec_mode = M_IMP;
            endcase
         end
         default: dec_mode = M_IMP;
      endcase
   end

   assign cur_count  = mode_count(mode);
   assign last_state = (state == STATE_W'(cur_count - 3'd1));

`ifdef PAGE_CROSS_PENALTY_EN
   logic penalty_mode;
   logic is_store;
   logic take_extra;

   // Indexed/indirect-indexed modes may need a fix-up cycle for the high
   // address byte. Stores always take it because the write cannot be
   // speculated. The extra state sits at index cur_count, so reaching it
   // is itself the exit condition.
   always_comb begin
      penalty_mode = (mode == M_ABS_X) || (mode == M_ABS_Y) || (mode == M_IND_Y);
      is_store     = (opcode_q[7:5] == 3'b100) && (opcode_q[1:0] == 2'b01);
      take_extra   = last_state && penalty_mode && (page_cross || is_store);
      exit_addr    = (last_state && !take_extra) || (state == STATE_W'(cur_count));
   end
`else
   logic unused_page_cross;

   assign unused_page_cross = page_cross;
   assign exit_addr         = last_state;
`endif

   // Next-state logic for the IDLE/ADDR/DONE sequencer. hold freezes
   // everything except the DONE handshake, which only waits on exec_ack.
   always_comb begin
      fsm_nxt     = fsm;
      opcode_nxt  = opcode_q;
      mode_nxt    = mode;
      state_nxt   = state;
      illegal_nxt = illegal;
      case (fsm)
         IDLE: begin
            if (opcode_valid && !hold) begin
               opcode_nxt  = opCode;
               mode_nxt    = dec_mode;
               illegal_nxt = (cc == 2'b11);
               state_nxt   = '0;
               fsm_nxt     = (mode_count(dec_mode) == 3'd0) ? DONE : ADDR;
            end
         end
         ADDR: begin
            if (!hold) begin
               if (exit_addr) begin
                  fsm_nxt   = DONE;
                  state_nxt = '0;
               end else begin
                  state_nxt = state + STATE_W'(1);
               end
            end
         end
         DONE: begin
            if (exec_ack)
               fsm_nxt = IDLE;
         end
         default: begin
            fsm_nxt   = IDLE;
            state_nxt = '0;
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         fsm      <= IDLE;
         opcode_q <= 8'h00;
         mode     <= M_IMP;
         state    <= '0;
         illegal  <= 1'b0;
      end else begin
         fsm      <= fsm_nxt;
         opcode_q <= opcode_nxt;
         mode     <= mode_nxt;
         state    <= state_nxt;
         illegal  <= illegal_nxt;
      end
   end

   assign opcode_ready = (fsm == IDLE);
   assign addr_active  = (fsm == ADDR);
   assign addr_done    = (fsm == DONE);

endmodule

// File: tb/tb_addr_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_addr_mode_sequencer
//
// Self-checking bench for addr_mode_sequencer. A transaction-level reference
// model (decode tables plus a remaining-states counter) predicts every output
// each cycle. Directed scenarios come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_addr_mode_sequencer;

   logic       clk = 1'b0;
   logic       nrst;
   logic       opcode_valid;
   logic [7:0] opCode;
   logic       hold;
   logic       exec_ack;
   logic       page_cross;
   logic       opcode_ready;
   logic [7:0] opcode_q;
   logic [3:0] mode;
   logic [3:0] state;
   logic       addr_active;
   logic       addr_done;
   logic       illegal;

   int checks = 0;
   int errors = 0;

   // Reference model: phase 0=idle, 1=issuing states, 2=waiting for ack.
   int         m_phase;
   int         m_state;
   int         m_remaining;
   int         m_mode;
   logic [7:0] m_opq;
   logic       m_illegal;
   logic       m_ext;

   int cc01_tbl [8] = '{8, 2, 1, 5, 9, 3, 7, 6};
   int cc10_tbl [8] = '{1, 2, 0, 5, 0, 3, 0, 6};
   int cc00_tbl [8] = '{0, 2, 0, 5, 10, 3, 0, 6};
   int cnt_tbl  [12] = '{0, 0, 1, 2, 2, 2, 3, 3, 3, 4, 0, 4};

   addr_mode_sequencer dut (
      .clk          (clk),
      .nrst         (nrst),
      .opcode_valid (opcode_valid),
      .opCode       (opCode),
      .hold         (hold),
      .exec_ack     (exec_ack),
      .page_cross   (page_cross),
      .opcode_ready (opcode_ready),
      .opcode_q     (opcode_q),
      .mode         (mode),
      .state        (state),
      .addr_active  (addr_active),
      .addr_done    (addr_done),
      .illegal      (illegal)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   function automatic int refMode(input logic [7:0] op);
      int a, b, c, m;
      a = int'(op[7:5]);
      b = int'(op[4:2]);
      c = int'(op[1:0]);
      m = 0;
      if (c == 1) begin
         m = cc01_tbl[b];
      end else if (c == 2) begin
         m = cc10_tbl[b];
         if (b == 5 && (a == 4 || a == 5)) m = 4;
         if (b == 7 && a == 5) m = 7;
      end else if (c == 0) begin
         m = cc00_tbl[b];
         if (b == 0 && a >= 5) m = 1;
         if (op == 8'h20) m = 5;
         if (op == 8'h6C) m = 11;
      end
      return m;
   endfunction

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic checkAll();
      checkOutput("opcode_ready", 32'(opcode_ready), 32'(m_phase == 0));
      checkOutput("opcode_q",     32'(opcode_q),     32'(m_opq));
      checkOutput("mode",         32'(mode),         32'(m_mode));
      checkOutput("state",        32'(state),        32'(m_state));
      checkOutput("addr_active",  32'(addr_active),  32'(m_phase == 1));
      checkOutput("addr_done",    32'(addr_done),    32'(m_phase == 2));
      checkOutput("illegal",      32'(illegal),      32'(m_illegal));
   endtask

   // Advance the reference model by one clock using the driven inputs.
   task automatic modelStep();
      if (!nrst) begin
         m_phase = 0; m_state = 0; m_remaining = 0; m_mode = 0;
         m_opq = 8'h00; m_illegal = 1'b0; m_ext = 1'b0;
      end else if (m_phase == 0) begin
         if (opcode_valid && !hold) begin
            m_opq       = opCode;
            m_mode      = refMode(opCode);
            m_illegal   = (opCode[1:0] == 2'b11);
            m_remaining = cnt_tbl[m_mode];
            m_state     = 0;
            m_ext       = 1'b0;
            m_phase     = (m_remaining == 0) ? 2 : 1;
         end
      end else if (m_phase == 1) begin
         if (!hold) begin
            if (m_remaining > 1) begin
               m_remaining--;
               m_state++;
            end else begin
`ifdef PAGE_CROSS_PENALTY_EN
               if (!m_ext && (m_mode == 6 || m_mode == 7 || m_mode == 9) &&
                   (page_cross || (m_opq[7:5] == 3'd4 && m_opq[1:0] == 2'd1))) begin
                  m_ext = 1'b1;
                  m_state++;
               end else begin
                  m_phase = 2;
                  m_state = 0;
               end
`else
               m_phase = 2;
               m_state = 0;
`endif
            end
         end
      end else begin
         if (exec_ack) m_phase = 0;
      end
   endtask

   // Drive one cycle of inputs, step the model on the edge, check on the
   // falling edge.
   task automatic applyStimulus(input logic rst_n, input logic v, input logic [7:0] op,
                                input logic h, input logic ack, input logic pc);
      nrst         = rst_n;
      opcode_valid = v;
      opCode       = op;
      hold         = h;
      exec_ack     = ack;
      page_cross   = pc;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkAll();
   endtask

   // Present an opcode, run with no stall, then acknowledge the done.
   task automatic runOpcode(input logic [7:0] op, input int cycles);
      applyStimulus(1'b1, 1'b1, op, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < cycles; i++)
         applyStimulus(1'b1, 1'b1, 8'hEA, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      nrst = 1'b0; opcode_valid = 1'b0; opCode = 8'h00;
      hold = 1'b0; exec_ack = 1'b0; page_cross = 1'b0;
      m_phase = 0; m_state = 0; m_remaining = 0; m_mode = 0;
      m_opq = 8'h00; m_illegal = 1'b0; m_ext = 1'b0;
      @(negedge clk);

      // Reset held for two cycles.
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // LDA abs, done held across a couple of un-acked cycles.
      applyStimulus(1'b1, 1'b1, 8'hAD, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

      // LDA abs,X with a two-cycle stall in A1.
      applyStimulus(1'b1, 1'b1, 8'hBD, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // Mode/length coverage, with new opcodes offered while busy.
      runOpcode(8'hB6, 3);
      runOpcode(8'h6C, 5);
      runOpcode(8'hA9, 2);
      runOpcode(8'hFF, 2);
      runOpcode(8'h20, 3);
      runOpcode(8'h91, 6);
      runOpcode(8'hBE, 4);
      runOpcode(8'hF0, 1);

      // Reset asserted mid-addressing at A1.
      applyStimulus(1'b1, 1'b1, 8'h6C, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(99) != 0),
                       ($urandom_range(1) == 1),
                       8'($urandom),
                       ($urandom_range(3) == 0),
                       ($urandom_range(2) == 0),
                       ($urandom_range(1) == 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/addr_mode_sequencer.md
Name: addr_mode_sequencer

Overview:
- Upstream stage of the per-mode addressing flag generators.
- Accepts a fetched opcode, latches it and decodes its 6502 addressing mode.
- Steps the addressing state counter A0..A5 that the flag generators consume, one state per unstalled cycle.
- When addressing completes, holds a done handshake until the execute stage acknowledges it.

Parameters:
- STATE_W, 4, width of the addressing state output (A0=0 … A5=5).
- MODE_W, 4, width of the addressing-mode code.

Ports:
- clk  in  1  system clock.
- nrst  in  1  synchronous active-low reset. Sampled on the rising edge of clk.
- opcode_valid  in  1  fetch presents a new opcode this cycle.
- opCode  in  8  fetched opcode.
- hold  in  1  stall (RDY low). Freezes the state counter and the FSM.
- exec_ack  in  1  execute stage has consumed addressing results.
- page_cross  in  1  ALU carry out of the low-address add (used only with the optional feature).
- opcode_ready  out  1  FSM in IDLE; an opcode is accepted this cycle.
- opcode_q  out  8  latched opcode.
- mode  out  MODE_W  decoded mode: 0 IMP, 1 IMM, 2 ZPG, 3 ZPG_X, 4 ZPG_Y, 5 ABS, 6 ABS_X, 7 ABS_Y, 8 IND_X, 9 IND_Y, 10 REL, 11 IND.
- state  out  STATE_W  current addressing state. Valid while addr_active.
- addr_active  out  1  addressing states are being issued.
- addr_done  out  1  addressing finished; held until exec_ack.
- illegal  out  1  latched opcode has cc=11.

Behaviour:
- Reset (nrst=0 at the clock edge): FSM=IDLE, opcode_q=0x00, mode=IMP, state=0, addr_active=0, addr_done=0, illegal=0. opcode_ready=1 in the first cycle after reset.
- Decode uses opCode fields aaa=[7:5], bbb=[4:2], cc=[1:0]:
  - cc=01: bbb 000 IND_X, 001 ZPG, 010 IMM, 011 ABS, 100 IND_Y, 101 ZPG_X, 110 ABS_Y, 111 ABS_X.
  - cc=10: bbb 000 IMM, 001 ZPG, 011 ABS, 101 ZPG_X, 111 ABS_X, all others IMP. Exceptions when aaa=100 or 101: bbb 101 becomes ZPG_Y; when aaa=101: bbb 111 becomes ABS_Y.
  - cc=00: bbb 000 is IMM if aaa≥101, otherwise IMP. 0x20 is ABS. bbb 001 ZPG, 011 ABS (0x6C is IND), 100 REL, 101 ZPG_X, 111 ABS_X, all others IMP.
  - cc=11: IMP, illegal=1.
- State count per mode:
  - 0: IMP, IMM, REL.
  - 1: ZPG.
  - 2: ZPG_X, ZPG_Y, ABS.
  - 3: ABS_X, ABS_Y, IND_X.
  - 4: IND_Y, IND.
- FSM IDLE/ADDR/DONE:
  - IDLE: if opcode_valid and !hold, latch opcode_q, mode and illegal. If the count is 0, go to DONE. Otherwise go to ADDR with state=A0 and addr_active=1.
  - ADDR: each cycle with !hold, state increments. When state==count-1 and !hold, go to DONE with addr_active=0 and state=0.
  - DONE: addr_done=1. On exec_ack (ignores hold), go to IDLE and clear addr_done.
  - Latency from opcode acceptance to addr_done = count+1 cycles.
- hold freezes the FSM, state, opcode_q and mode in every FSM state except DONE.
- opcode_valid outside IDLE is ignored. No queueing.
- exec_ack outside DONE is ignored.
- State never exceeds A5. Reaching A5 without the exit condition is unreachable by design.

Optional Feature:
- Macro PAGE_CROSS_PENALTY_EN.
- Defined: for ABS_X, ABS_Y and IND_Y, page_cross is sampled in the final state. If it is 1, one extra state is issued before DONE (count+1). The extra state is always issued for stores, i.e. opcode_q with aaa=100 and cc=01.
- Undefined: page_cross is ignored and counts are fixed as listed.

Test Plan:
- Reset: hold nrst=0 for 2 cycles → mode=0, state=0, addr_active=0, addr_done=0, opcode_ready=1.
- opCode=0xAD (LDA abs), no hold → mode=5, state A0 then A1, addr_done=1 at cycle 3. It stays 1 until exec_ack, then the FSM returns to IDLE.
- opCode=0xBD (LDA abs,X), hold=1 during A1 for 2 cycles → state sequence A0, A1, A1, A1, A2, then done. With PAGE_CROSS_PENALTY_EN and page_cross=1 in A2 → an extra A3 before done.
- opCode=0xB6 (LDX zpg,Y) → mode=4, 2 states. opCode=0x6C → mode=11, 4 states. opCode=0xA9 → mode=1, addr_done 1 cycle after acceptance, addr_active never set.
- opCode=0xFF → illegal=1, mode=0. A new opcode_valid arriving in ADDR or DONE does not change opcode_q.
- nrst=0 asserted mid-ADDR at state A1 → all outputs return to reset values on the next edge.
